axi_ar_arbiter: RTL and testbench

AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

---
 rtl/axi_ar_arbiter_pkg.sv | 38 +++
 rtl/axi_ar_arbiter_rr_arbiter.sv | 32 +++
 rtl/axi_ar_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_ar_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ar_arbiter_pkg.sv
// Shared types and width helpers for the AXI AR arbiter slice.
// Holds the output-stage state encoding and the common AR payload record.
package axi_ar_arbiter_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ID_WIDTH    = 4;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int DEF_SIZE_WIDTH  = 3;
  localparam int DEF_BURST_WIDTH = 2;
  localparam int DEF_QOS_WIDTH   = 4;

  function automatic int idx_w(input int num_masters);
    return $clog2(num_masters);
  endfunction

  function automatic int out_id_w(input int num_masters, input int id_width);
    return idx_w(num_masters) + id_width;
  endfunction

  localparam int DEF_OUT_ID_W = out_id_w(DEF_NUM_MASTERS, DEF_ID_WIDTH);

  // Payload as seen on the ROB side: id already carries the master index.
  typedef struct packed {
    logic [DEF_OUT_ID_W-1:0]    id;
    logic [DEF_ADDR_WIDTH-1:0]  addr;
    logic [DEF_LEN_WIDTH-1:0]   len;
    logic [DEF_SIZE_WIDTH-1:0]  size;
    logic [DEF_BURST_WIDTH-1:0] burst;
    logic [DEF_QOS_WIDTH-1:0]   qos;
  } ar_payload_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/axi_ar_arbiter_rr_arbiter.sv
// Round-robin selector: first requester at or above ptr wins, wrapping.
// Grant is one-hot; valid is high whenever any request is present.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // N is a power of two, so ptr + k wraps modulo N for free.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/axi_ar_arbiter.sv
// Credit-limited round-robin AR arbiter in front of a shared ROB ingress,
// with combinational R routing back to the requesting master.
module axi_ar_arbiter
  import axi_ar_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int QOS_WIDTH   = DEF_QOS_WIDTH,
  parameter int MAX_CREDITS = 4,
  localparam int IDX_W      = idx_w(NUM_MASTERS),
  localparam int OUT_ID_W   = out_id_w(NUM_MASTERS, ID_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [NUM_MASTERS-1:0]             m_ar_valid,
  output logic [NUM_MASTERS-1:0]             m_ar_ready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]    m_ar_id,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_ar_addr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]   m_ar_len,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]  m_ar_size,
  input  logic [NUM_MASTERS*BURST_WIDTH-1:0] m_ar_burst,
  input  logic [NUM_MASTERS*QOS_WIDTH-1:0]   m_ar_qos,

  output logic                              s_ar_valid,
  input  logic                              s_ar_ready,
  output logic [OUT_ID_W-1:0]               s_ar_id,
  output logic [ADDR_WIDTH-1:0]             s_ar_addr,
  output logic [LEN_WIDTH-1:0]              s_ar_len,
  output logic [SIZE_WIDTH-1:0]             s_ar_size,
  output logic [BURST_WIDTH-1:0]            s_ar_burst,
  output logic [QOS_WIDTH-1:0]              s_ar_qos,

  input  logic                              s_r_valid,
  output logic                              s_r_ready,
  input  logic [OUT_ID_W-1:0]               s_r_id,
  input  logic [63:0]                       s_r_data,
  input  logic [1:0]                        s_r_resp,
  input  logic                              s_r_last,

  output logic [NUM_MASTERS-1:0]             m_r_valid,
  input  logic [NUM_MASTERS-1:0]             m_r_ready,
  output logic [ID_WIDTH-1:0]               m_r_id,
  output logic [63:0]                       m_r_data,
  output logic [1:0]                        m_r_resp,
  output logic                              m_r_last,

  output logic                              credit_err
);

  localparam int CRED_W = $clog2(MAX_CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_CREDITS);

  out_state_e       state_reg, state_next;
  ar_payload_t      ar_reg, ar_next;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [CRED_W-1:0] credit_reg [NUM_MASTERS];
  logic             credit_err_reg;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] cred_dec;
  logic [NUM_MASTERS-1:0] cred_inc;
  logic [NUM_MASTERS-1:0] cred_ovf;
  logic                   arb_valid;
  logic                   accept_allowed;
  logic                   accept;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_done;

  assign r_idx  = s_r_id[OUT_ID_W-1 -: IDX_W];
  assign r_done = s_r_valid && s_r_ready && s_r_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign eligible[gi]  = m_ar_valid[gi] && (credit_reg[gi] != '0);
      assign cred_dec[gi]  = accept && grant[gi];
      assign cred_inc[gi]  = r_done && (r_idx == IDX_W'(gi));
      assign cred_ovf[gi]  = cred_inc[gi] && !cred_dec[gi] && (credit_reg[gi] == CRED_MAX);
      assign m_ar_ready[gi] = accept_allowed && grant[gi];
      assign m_r_valid[gi]  = s_r_valid && (r_idx == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) win_idx = win_idx | IDX_W'(i);
    end
  end

  // Output stage: accept when empty, or when the held AR leaves this cycle.
  always_comb begin
    state_next     = state_reg;
    accept_allowed = 1'b0;
    case (state_reg)
      ST_EMPTY: accept_allowed = rst;
      ST_FULL:  accept_allowed = rst && s_ar_ready;
      default:  accept_allowed = 1'b0;
    endcase
    accept = accept_allowed && arb_valid;
    if (accept) begin
      state_next = ST_FULL;
    end else if (state_reg == ST_FULL && s_ar_ready) begin
      state_next = ST_EMPTY;
    end
  end

  always_comb begin
    ar_next       = '0;
    ar_next.id    = {win_idx, m_ar_id[win_idx*ID_WIDTH +: ID_WIDTH]};
    ar_next.addr  = m_ar_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    ar_next.len   = m_ar_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    ar_next.size  = m_ar_size[win_idx*SIZE_WIDTH +: SIZE_WIDTH];
    ar_next.burst = m_ar_burst[win_idx*BURST_WIDTH +: BURST_WIDTH];
    ar_next.qos   = m_ar_qos[win_idx*QOS_WIDTH +: QOS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_EMPTY;
      ar_reg     <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ar_reg     <= ar_next;
        rr_ptr_reg <= win_idx + IDX_W'(1);
      end
    end
  end

  // A return and an issue on the same master cancel; overflow saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_MASTERS; i++) credit_reg[i] <= CRED_MAX;
      credit_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (cred_inc[i] && !cred_dec[i]) begin
          if (credit_reg[i] != CRED_MAX) credit_reg[i] <= credit_reg[i] + CRED_W'(1);
        end else if (cred_dec[i] && !cred_inc[i]) begin
          credit_reg[i] <= credit_reg[i] - CRED_W'(1);
        end
      end
      if (|cred_ovf) credit_err_reg <= 1'b1;
    end
  end

  assign s_ar_valid = (state_reg == ST_FULL);
  assign s_ar_id    = ar_reg.id;
  assign s_ar_addr  = ar_reg.addr;
  assign s_ar_len   = ar_reg.len;
  assign s_ar_size  = ar_reg.size;
  assign s_ar_burst = ar_reg.burst;
  assign s_ar_qos   = ar_reg.qos;

  assign s_r_ready  = m_r_ready[r_idx];
  assign m_r_id     = s_r_id[ID_WIDTH-1:0];
  assign m_r_data   = s_r_data;
  assign m_r_resp   = s_r_resp;
  assign m_r_last   = s_r_last;

  assign credit_err = credit_err_reg;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed self-checking bench for axi_ar_arbiter (default parameters).
module tb_axi_ar_arbiter;

  localparam int NM = 4, IDW = 4, AW = 32, LW = 8, SW = 3, BW = 2, QW = 4, OIDW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NM-1:0]     m_ar_valid, m_ar_ready;
  logic [NM*IDW-1:0] m_ar_id;
  logic [NM*AW-1:0]  m_ar_addr;
  logic [NM*LW-1:0]  m_ar_len;
  logic [NM*SW-1:0]  m_ar_size;
  logic [NM*BW-1:0]  m_ar_burst;
  logic [NM*QW-1:0]  m_ar_qos;
  logic              s_ar_valid, s_ar_ready;
  logic [OIDW-1:0]   s_ar_id;
  logic [AW-1:0]     s_ar_addr;
  logic [LW-1:0]     s_ar_len;
  logic [SW-1:0]     s_ar_size;
  logic [BW-1:0]     s_ar_burst;
  logic [QW-1:0]     s_ar_qos;
  logic              s_r_valid, s_r_ready;
  logic [OIDW-1:0]   s_r_id;
  logic [63:0]       s_r_data;
  logic [1:0]        s_r_resp;
  logic              s_r_last;
  logic [NM-1:0]     m_r_valid, m_r_ready;
  logic [IDW-1:0]    m_r_id;
  logic [63:0]       m_r_data;
  logic [1:0]        m_r_resp;
  logic              m_r_last;
  logic              credit_err;

  int checks = 0;
  int errors = 0;

  axi_ar_arbiter dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_qos(m_ar_qos),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_qos(s_ar_qos),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .credit_err(credit_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_ar_valid = '0; m_ar_id = '0; m_ar_addr = '0; m_ar_len = '0;
    m_ar_size = '0; m_ar_burst = '0; m_ar_qos = '0;
    s_ar_ready = 1'b0;
    s_r_valid = 1'b0; s_r_id = '0; s_r_data = '0; s_r_resp = '0; s_r_last = 1'b0;
    m_r_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_ar(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr);
    m_ar_id[m*IDW +: IDW] = id;
    m_ar_addr[m*AW +: AW] = addr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    m_ar_valid = '1;
    s_ar_ready = 1'b1;
    tick();
    tick();
    checks++; if (m_ar_ready !== 4'b0000) begin errors++; $display("FAIL reset_m_ar_ready: got %b expected 0000", m_ar_ready); end
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_s_ar_valid: got %b expected 0", s_ar_valid); end
    checks++; if (s_ar_id !== 6'h00 || s_ar_addr !== 32'h0) begin errors++; $display("FAIL reset_payload: got id %h addr %h expected 0", s_ar_id, s_ar_addr); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
    checks++; if (dut.credit_reg[0] !== 3'd4 || dut.credit_reg[3] !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d/%0d expected 4/4", dut.credit_reg[0], dut.credit_reg[3]); end
    m_ar_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_ar(2, 4'h5, 32'h1000);
    m_ar_valid = 4'b0100;
    s_ar_ready = 1'b1;
    #1;
    checks++; if (m_ar_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", m_ar_ready); end
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got s_ar_valid %b expected 0 before edge", s_ar_valid); end
    tick();
    m_ar_valid = '0;
    checks++; if (s_ar_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", s_ar_valid); end
    checks++; if (s_ar_id !== 6'h25) begin errors++; $display("FAIL single_id: got %h expected 25", s_ar_id); end
    checks++; if (s_ar_addr !== 32'h1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", s_ar_addr); end
    checks++; if (dut.credit_reg[2] !== 3'd3) begin errors++; $display("FAIL single_credit: got %0d expected 3", dut.credit_reg[2]); end
    tick();
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", s_ar_valid); end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0]   exp_ready;
    logic [OIDW-1:0] exp_id;
    do_reset();
    for (int i = 0; i < NM; i++) set_ar(i, IDW'(i), AW'(32'h100 * (i + 1)));
    m_ar_valid = '1;
    s_ar_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_ready = NM'(1) << (k % 4);
      exp_id    = OIDW'((k % 4) * 16 + (k % 4));
      #1;
      checks++; if (m_ar_ready !== exp_ready) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, m_ar_ready, exp_ready); end
      tick();
      checks++; if (s_ar_valid !== 1'b1 || s_ar_id !== exp_id) begin errors++; $display("FAIL rr_out%0d: got valid %b id %h expected 1 %h", k, s_ar_valid, s_ar_id, exp_id); end
    end
    m_ar_valid = '0;
    tick();
  endtask

  task automatic test_credit_limit();
    do_reset();
    s_ar_ready = 1'b1;
    m_ar_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_ar(1, IDW'(k), AW'(32'h2000 + 16 * k));
      #1;
      checks++; if (m_ar_ready !== 4'b0010) begin errors++; $display("FAIL credit_issue%0d: got %b expected 0010", k, m_ar_ready); end
      tick();
    end
    set_ar(1, 4'h4, 32'h2040);
    #1;
    checks++; if (m_ar_ready !== 4'b0000) begin errors++; $display("FAIL credit_stall: got %b expected 0000", m_ar_ready); end
    tick();
    checks++; if (m_ar_ready !== 4'b0000 || s_ar_valid !== 1'b0) begin errors++; $display("FAIL credit_stall2: got ready %b valid %b expected 0000 0", m_ar_ready, s_ar_valid); end
    s_r_valid = 1'b1; s_r_id = 6'h13; s_r_last = 1'b1; m_r_ready = 4'b0010;
    #1;
    checks++; if (s_r_ready !== 1'b1 || m_ar_ready !== 4'b0000) begin errors++; $display("FAIL credit_return: got s_r_ready %b m_ar_ready %b expected 1 0000", s_r_ready, m_ar_ready); end
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    #1;
    checks++; if (m_ar_ready !== 4'b0010) begin errors++; $display("FAIL credit_resume: got %b expected 0010", m_ar_ready); end
    tick();
    m_ar_valid = '0;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_id !== 6'h14 || s_ar_addr !== 32'h2040) begin errors++; $display("FAIL credit_fifth: got valid %b id %h addr %h expected 1 14 00002040", s_ar_valid, s_ar_id, s_ar_addr); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_ar(0, 4'h9, 32'h0ABC);
    set_ar(1, 4'h3, 32'hDEF0);
    m_ar_valid = 4'b0001;
    #1;
    checks++; if (m_ar_ready !== 4'b0001) begin errors++; $display("FAIL stall_first: got %b expected 0001", m_ar_ready); end
    tick();
    m_ar_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m_ar_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0000", c, m_ar_ready); end
      checks++; if (s_ar_valid !== 1'b1 || s_ar_id !== 6'h09 || s_ar_addr !== 32'h0ABC) begin errors++; $display("FAIL stall_hold%0d: got valid %b id %h addr %h expected 1 09 00000abc", c, s_ar_valid, s_ar_id, s_ar_addr); end
      tick();
    end
    s_ar_ready = 1'b1;
    #1;
    checks++; if (m_ar_ready !== 4'b0010) begin errors++; $display("FAIL stall_release: got %b expected 0010", m_ar_ready); end
    tick();
    m_ar_valid = '0;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_id !== 6'h13 || s_ar_addr !== 32'hDEF0) begin errors++; $display("FAIL stall_b2b: got valid %b id %h addr %h expected 1 13 0000def0", s_ar_valid, s_ar_id, s_ar_addr); end
    tick();
  endtask

  task automatic test_r_route();
    do_reset();
    set_ar(3, 4'h7, 32'h3000);
    m_ar_valid = 4'b1000;
    s_ar_ready = 1'b1;
    tick();
    m_ar_valid = '0;
    checks++; if (dut.credit_reg[3] !== 3'd3) begin errors++; $display("FAIL route_pre_credit: got %0d expected 3", dut.credit_reg[3]); end
    s_r_valid = 1'b1; s_r_id = 6'h37; s_r_last = 1'b1;
    s_r_data = 64'hDEAD_BEEF_0123_4567; s_r_resp = 2'b10; m_r_ready = 4'b0000;
    #1;
    checks++; if (m_r_valid !== 4'b1000) begin errors++; $display("FAIL route_valid: got %b expected 1000", m_r_valid); end
    checks++; if (m_r_id !== 4'h7) begin errors++; $display("FAIL route_id: got %h expected 7", m_r_id); end
    checks++; if (s_r_ready !== 1'b0) begin errors++; $display("FAIL route_ready_low: got %b expected 0", s_r_ready); end
    checks++; if (m_r_data !== 64'hDEAD_BEEF_0123_4567 || m_r_resp !== 2'b10 || m_r_last !== 1'b1) begin errors++; $display("FAIL route_payload: got %h %b %b expected deadbeef01234567 10 1", m_r_data, m_r_resp, m_r_last); end
    tick();
    checks++; if (dut.credit_reg[3] !== 3'd3) begin errors++; $display("FAIL route_hold_credit: got %0d expected 3", dut.credit_reg[3]); end
    m_r_ready = 4'b0111;
    #1;
    checks++; if (s_r_ready !== 1'b0) begin errors++; $display("FAIL route_other_ready: got %b expected 0", s_r_ready); end
    tick();
    m_r_ready = 4'b1000;
    #1;
    checks++; if (s_r_ready !== 1'b1) begin errors++; $display("FAIL route_ready_high: got %b expected 1", s_r_ready); end
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    checks++; if (dut.credit_reg[3] !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("FAIL route_credit_back: got %0d err %b expected 4 0", dut.credit_reg[3], credit_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_ar(1, 4'h1, 32'h4000);
    m_ar_valid = 4'b0010;
    s_ar_ready = 1'b1;
    tick();
    checks++; if (dut.credit_reg[1] !== 3'd3) begin errors++; $display("FAIL same_pre_credit: got %0d expected 3", dut.credit_reg[1]); end
    s_r_valid = 1'b1; s_r_id = 6'h11; s_r_last = 1'b1; m_r_ready = 4'b1111;
    #1;
    checks++; if (m_ar_ready !== 4'b0010) begin errors++; $display("FAIL same_grant: got %b expected 0010", m_ar_ready); end
    tick();
    m_ar_valid = '0; s_r_valid = 1'b0; s_r_last = 1'b0;
    checks++; if (dut.credit_reg[1] !== 3'd3 || credit_err !== 1'b0) begin errors++; $display("FAIL same_credit: got %0d err %b expected 3 0", dut.credit_reg[1], credit_err); end
  endtask

  task automatic test_spurious();
    do_reset();
    s_r_valid = 1'b1; s_r_id = 6'h02; s_r_last = 1'b1; m_r_ready = 4'b0001;
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    checks++; if (dut.credit_reg[0] !== 3'd4) begin errors++; $display("FAIL spur_credit: got %0d expected 4", dut.credit_reg[0]); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b expected 1", credit_err); end
    tick();
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b expected 1", credit_err); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b expected 0", credit_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ar(2, 4'hA, 32'h5000);
    m_ar_valid = 4'b0100;
    tick();
    m_ar_valid = '0;
    checks++; if (s_ar_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", s_ar_valid); end
    rst = 1'b0;
    tick();
    checks++; if (s_ar_valid !== 1'b0 || dut.credit_reg[2] !== 3'd4) begin errors++; $display("FAIL mid_drop: got valid %b credit %0d expected 0 4", s_ar_valid, dut.credit_reg[2]); end
    rst = 1'b1;
    tick();
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay: got %b expected 0", s_ar_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_stall();
    test_r_route();
    test_same_cycle();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
